// File: rtl/det_counter.sv
// det_counter: edge-triggered BCD detection counter with sticky overflow and muxed 7-segment display
module det_counter #(
  parameter int REFRESH_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       ovf,
  output logic       det_pulse,
  output logic [6:0] seg,
  output logic [1:0] an
);
  logic                    det_q;
  logic [REFRESH_BITS-1:0] refresh;
  logic                    inc;
  logic                    sel;
  logic                    blank;
  logic [3:0]              digit;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
  endfunction

  assign inc = det & ~det_q & en & ~clr;

  // Edge history and refresh run every cycle; clr beats a simultaneous rise and drops it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_q     <= 1'b0;
      refresh   <= '0;
      ones      <= 4'd0;
      tens      <= 4'd0;
      ovf       <= 1'b0;
      det_pulse <= 1'b0;
    end else begin
      det_q   <= det;
      refresh <= refresh + 1'b1;
      if (clr) begin
        ones      <= 4'd0;
        tens      <= 4'd0;
        ovf       <= 1'b0;
        det_pulse <= 1'b0;
      end else begin
        det_pulse <= inc;
        if (inc) begin
          ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
          tens <= (ones == 4'd9) ? ((tens == 4'd9) ? 4'd0 : tens + 4'd1) : tens;
          ovf  <= ovf | ((ones == 4'd9) && (tens == 4'd9));
        end
      end
    end
  end

  // Display mux driven only by registered state; a zero tens digit is blanked
  always_comb begin
    sel   = refresh[REFRESH_BITS-1];
    blank = sel && (tens == 4'd0);
    digit = sel ? tens : ones;
    an    = blank ? 2'b11 : (sel ? 2'b01 : 2'b10);
    seg   = blank ? 7'b1111111 : pattern(digit);
  end
endmodule
